// File: rtl/pdp8_panel_ctrl_if.sv
// Front-panel bundle between the board buttons, the core run state and the core control strobes.
interface pdp8_panel_ctrl_if;
    logic nBUT1;
    logic nBUT2;
    logic cpu_running;
    logic sw_RESET;
    logic sw_CLEAR;
    logic sw_RUN;
    logic sw_HALT;
    logic busy;

    modport master (
        output nBUT1, nBUT2, cpu_running,
        input  sw_RESET, sw_CLEAR, sw_RUN, sw_HALT, busy
    );

    modport slave (
        input  nBUT1, nBUT2, cpu_running,
        output sw_RESET, sw_CLEAR, sw_RUN, sw_HALT, busy
    );
endinterface

// File: rtl/pdp8_panel_ctrl.sv
// PDP8 front-panel sequencer: button conditioning, power-on reset/clear,
// RUN/HALT toggling and short/long CLEAR/RESET handling.
module pdp8_panel_ctrl #(
    parameter int unsigned DEBOUNCE   = 250000,
    parameter int unsigned LONGPRESS  = 25000000,
    parameter int unsigned POR_CYCLES = 16,
    parameter int unsigned AUTORUN    = 0,
    parameter int unsigned CNTW       = 25
) (
    input  logic              clk,
    input  logic              reset,
    pdp8_panel_ctrl_if.slave  pif
);

    typedef enum logic [2:0] {
        S_POR, S_CLR, S_RUNP, S_IDLE, S_HOLD, S_RST, S_WREL
    } state_t;

    localparam logic [CNTW-1:0] DEB_LAST  = CNTW'(DEBOUNCE - 1);
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(LONGPRESS - 1);
    localparam logic [CNTW-1:0] POR_LAST  = CNTW'(POR_CYCLES - 1);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] x);
        return (&x) ? x : x + CNTW'(1);
    endfunction

    // Bit 0 = BUT1, bit 1 = BUT2; all active high after inversion.
    logic [1:0]           sync1_q, sync2_q, deb_q, deb_d, deb_prev_q;
    logic [1:0][CNTW-1:0] dcnt_q, dcnt_d;
    logic [1:0]           press;

    state_t               state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic                 long_q, long_d;
    logic                 sw_reset_q, sw_reset_d;
    logic                 sw_clear_q, sw_clear_d;
    logic                 sw_run_q, sw_run_d;
    logic                 sw_halt_q, sw_halt_d;
    logic                 busy_q, busy_d;

    assign press = deb_q & ~deb_prev_q;

    // Debounce: accept a new level only after DEBOUNCE consecutive differing samples.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]  = deb_q[i];
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] >= DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = sat_inc(dcnt_q[i]);
                end
            end
        end
    end

    // Sequencer next state; outputs are decoded from the next state and registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        long_d     = long_q;
        sw_clear_d = 1'b0;
        sw_run_d   = 1'b0;
        sw_halt_d  = 1'b0;
        unique case (state_q)
            S_POR, S_RST: begin
                if (cnt_q >= POR_LAST) begin
                    state_d = S_CLR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_CLR: begin
                long_d = 1'b0;
                if (long_q) begin
                    state_d = S_WREL;
                end else if (AUTORUN != 0) begin
                    state_d = S_RUNP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUNP: state_d = S_IDLE;
            S_IDLE: begin
                if (press[1]) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (press[0]) begin
                    sw_halt_d = pif.cpu_running;
                    sw_run_d  = ~pif.cpu_running;
                end
            end
            S_HOLD: begin
                if (!deb_q[1]) begin
                    state_d    = S_IDLE;
                    sw_clear_d = ~pif.cpu_running;
                end else if (cnt_q >= HOLD_LAST) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_WREL: begin
                if (!deb_q[1]) state_d = S_IDLE;
            end
            default: state_d = S_POR;
        endcase
        if (state_d == S_CLR)  sw_clear_d = 1'b1;
        if (state_d == S_RUNP) sw_run_d   = 1'b1;
        sw_reset_d = (state_d == S_POR) || (state_d == S_RST);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            dcnt_q     <= '0;
            state_q    <= S_POR;
            cnt_q      <= '0;
            long_q     <= 1'b0;
            sw_reset_q <= 1'b1;
            sw_clear_q <= 1'b0;
            sw_run_q   <= 1'b0;
            sw_halt_q  <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            sync1_q    <= {~pif.nBUT2, ~pif.nBUT1};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            dcnt_q     <= dcnt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            long_q     <= long_d;
            sw_reset_q <= sw_reset_d;
            sw_clear_q <= sw_clear_d;
            sw_run_q   <= sw_run_d;
            sw_halt_q  <= sw_halt_d;
            busy_q     <= busy_d;
        end
    end

    assign pif.sw_RESET = sw_reset_q;
    assign pif.sw_CLEAR = sw_clear_q;
    assign pif.sw_RUN   = sw_run_q;
    assign pif.sw_HALT  = sw_halt_q;
    assign pif.busy     = busy_q;

endmodule
